// File: rtl/stitch_fetch_sched_pkg.sv
// rtl/stitch_fetch_sched_pkg.sv - shared types and defaults for the stitched line-fetch scheduler
package stitch_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_SRC0 = 2'd2,
    S_SRC1 = 2'd3
  } state_t;

  localparam int BURST_LEN_DEF = 64;
  localparam int ADDR_W_DEF    = 28;
  localparam int RD_LEN_W      = 8;

endpackage

// File: rtl/stitch_fetch_sched_if.sv
// rtl/stitch_fetch_sched_if.sv - burst read request port towards the DDR read arbiter
interface stitch_fetch_sched_if
  import stitch_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
);

  logic                rd_req;
  logic                rd_ack;
  logic                rd_src;
  logic [ADDR_W-1:0]   rd_addr;
  logic [RD_LEN_W-1:0] rd_len;

  modport master (output rd_req, rd_src, rd_addr, rd_len, input rd_ack);
  modport slave  (input rd_req, rd_src, rd_addr, rd_len, output rd_ack);

endinterface

// File: rtl/stitch_fetch_sched_edge.sv
// rtl/stitch_fetch_sched_edge.sv - two-flop delay line with a rise or fall pulse
module sync_edge_det #(
  parameter bit RISE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic pulse
);

  logic d1;
  logic d2;

  always_ff @(posedge clk) begin
    if (rst) begin
      d1 <= 1'b0;
      d2 <= 1'b0;
    end else begin
      d1 <= din;
      d2 <= d1;
    end
  end

  assign pulse = RISE ? (d1 & ~d2) : (~d1 & d2);

endmodule

// File: rtl/stitch_fetch_sched.sv
// rtl/stitch_fetch_sched.sv - fetches each display line one line ahead as a left burst run
// from frame buffer 0 followed by a right burst run from frame buffer 1
module stitch_fetch_sched
  import stitch_pkg::*;
#(
  parameter int SEG0_W    = 1920,
  parameter int SEG1_W    = 960,
  parameter int V_DISP    = 1080,
  parameter int BURST_LEN = BURST_LEN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int SRC0_BASE = 0,
  parameter int SRC1_BASE = 'h400000,
  parameter int STRIDE    = 1920,
  parameter int SRC1_XOFF = 960
) (
  input  logic                 pixel_clk,
  input  logic                 sys_rst,
  input  logic                 video_vs,
  input  logic                 video_de,
  stitch_fetch_sched_if.master rd,
  output logic [11:0]          line_idx,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [7:0]        LAST_BURST0 = 8'(SEG0_W / BURST_LEN - 1);
  localparam logic [7:0]        LAST_BURST1 = 8'(SEG1_W / BURST_LEN - 1);
  localparam logic [11:0]       LAST_LINE   = 12'(V_DISP - 1);
  localparam logic [ADDR_W-1:0] BASE0_INIT  = ADDR_W'(SRC0_BASE);
  localparam logic [ADDR_W-1:0] BASE1_INIT  = ADDR_W'(SRC1_BASE + SRC1_XOFF);
  localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(STRIDE);
  localparam logic [ADDR_W-1:0] BURST_A     = ADDR_W'(BURST_LEN);

  state_t            state;
  state_t            state_nx;
  logic              frame_trig;
  logic              line_trig;
  logic              frame_q;
  logic              line_q;
  logic              restart;
  logic              pending;
  logic [7:0]        burst;
  logic [ADDR_W-1:0] base0;
  logic [ADDR_W-1:0] base1;

  logic              frame_ev;
  logic              take_frame;
  logic              line_ev;
  logic              ack_fire;
  logic              in_fetch;
  logic              seg_done;
  logic              line_end;
  logic              last_line;
  logic              pend_now;

  logic              req_nx;
  logic              src_nx;
  logic [ADDR_W-1:0] addr_nx;
  logic              busy_nx;

  sync_edge_det #(.RISE(1'b1)) u_vs_edge (
    .clk   (pixel_clk),
    .rst   (sys_rst),
    .din   (video_vs),
    .pulse (frame_trig)
  );

  sync_edge_det #(.RISE(1'b0)) u_de_edge (
    .clk   (pixel_clk),
    .rst   (sys_rst),
    .din   (video_de),
    .pulse (line_trig)
  );

  // A frame restart never withdraws an outstanding request; it waits until rd_req is low.
  assign frame_ev   = frame_q | restart;
  assign take_frame = frame_ev & ~rd.rd_req;
  assign line_ev    = line_q & ~frame_ev;
  assign ack_fire   = rd.rd_req & rd.rd_ack;
  assign in_fetch   = (state == S_SRC0) || (state == S_SRC1);
  assign seg_done   = ack_fire && (burst == ((state == S_SRC1) ? LAST_BURST1 : LAST_BURST0));
  assign line_end   = seg_done && (state == S_SRC1);
  assign last_line  = (line_idx == LAST_LINE);
  assign pend_now   = pending | line_ev;
  assign rd.rd_len  = RD_LEN_W'(BURST_LEN);

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      state      <= S_IDLE;
      rd.rd_req  <= 1'b0;
      rd.rd_src  <= 1'b0;
      rd.rd_addr <= '0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nx;
      rd.rd_req  <= req_nx;
      rd.rd_src  <= src_nx;
      rd.rd_addr <= addr_nx;
      busy       <= busy_nx;
    end
  end

  always_comb begin
    state_nx = state;
    if (take_frame) begin
      state_nx = S_SRC0;
    end else begin
      case (state)
        S_WAIT: if (line_ev) state_nx = S_SRC0;
        S_SRC0: if (seg_done) state_nx = S_SRC1;
        S_SRC1: begin
          if (line_end) begin
            if (last_line)     state_nx = S_IDLE;
            else if (pend_now) state_nx = S_SRC0;
            else               state_nx = S_WAIT;
          end
        end
        default: state_nx = state;
      endcase
    end
  end

  // Dropping rd_req for a cycle after every ack keeps requests at most one per two cycles.
  always_comb begin
    req_nx  = rd.rd_req;
    src_nx  = rd.rd_src;
    addr_nx = rd.rd_addr;
    if (take_frame) begin
      req_nx  = 1'b1;
      src_nx  = 1'b0;
      addr_nx = BASE0_INIT;
    end else if (ack_fire) begin
      req_nx = 1'b0;
    end else if (!rd.rd_req && (state_nx == S_SRC0 || state_nx == S_SRC1)) begin
      req_nx  = 1'b1;
      src_nx  = (state_nx == S_SRC1);
      addr_nx = ((state_nx == S_SRC1) ? base1 : base0) + ADDR_W'(burst) * BURST_A;
    end
    busy_nx = (state_nx == S_SRC0) || (state_nx == S_SRC1);
  end

  always_ff @(posedge pixel_clk) begin
    if (sys_rst) begin
      frame_q  <= 1'b0;
      line_q   <= 1'b0;
      restart  <= 1'b0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
      burst    <= '0;
      line_idx <= '0;
      base0    <= '0;
      base1    <= '0;
    end else begin
      frame_q <= frame_trig;
      line_q  <= line_trig;
      if (take_frame) begin
        restart  <= 1'b0;
        pending  <= 1'b0;
        overrun  <= 1'b0;
        burst    <= '0;
        line_idx <= '0;
        base0    <= BASE0_INIT;
        base1    <= BASE1_INIT;
      end else begin
        if (frame_ev) restart <= 1'b1;
        if (line_ev && in_fetch) begin
          overrun <= 1'b1;
          pending <= 1'b1;
        end
        if (ack_fire) begin
          burst <= seg_done ? 8'd0 : burst + 8'd1;
          if (line_end && !last_line) begin
            line_idx <= line_idx + 12'd1;
            base0    <= base0 + STRIDE_A;
            base1    <= base1 + STRIDE_A;
            if (pend_now) pending <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_stitch_fetch_sched.sv
// tb/tb_stitch_fetch_sched.sv - randomized-ack bench against a line/segment request model
module tb_stitch_fetch_sched;

  localparam int SEG0_W    = 128;
  localparam int SEG1_W    = 64;
  localparam int BL        = 64;
  localparam int V_DISP    = 4;
  localparam int STRIDE    = 256;
  localparam int SRC0_BASE = 0;
  localparam int SRC1_BASE = 'h10000;
  localparam int SRC1_XOFF = 64;
  localparam int ADDR_W    = 28;

  typedef struct packed {
    logic        src;
    logic [27:0] addr;
    logic [11:0] line;
  } req_t;

  logic        pixel_clk = 1'b0;
  logic        sys_rst   = 1'b1;
  logic        video_vs  = 1'b0;
  logic        video_de  = 1'b0;
  logic [11:0] line_idx;
  logic        busy;
  logic        overrun;

  stitch_fetch_sched_if #(.ADDR_W(ADDR_W)) rd_if ();

  stitch_fetch_sched #(
    .SEG0_W(SEG0_W), .SEG1_W(SEG1_W), .V_DISP(V_DISP), .BURST_LEN(BL), .ADDR_W(ADDR_W),
    .SRC0_BASE(SRC0_BASE), .SRC1_BASE(SRC1_BASE), .STRIDE(STRIDE), .SRC1_XOFF(SRC1_XOFF)
  ) dut (
    .pixel_clk (pixel_clk),
    .sys_rst   (sys_rst),
    .video_vs  (video_vs),
    .video_de  (video_de),
    .rd        (rd_if),
    .line_idx  (line_idx),
    .busy      (busy),
    .overrun   (overrun)
  );

  always #5 pixel_clk = ~pixel_clk;

  int          n_chk  = 0;
  int          n_fail = 0;
  req_t        exp_q[$];
  bit          waiting  = 0;
  bit          just_acc = 0;
  int          wait_left = 0;
  int          lo = 0;
  int          hi = 0;
  int          n_acc = 0;
  logic        cur_src;
  logic [27:0] cur_addr;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every line is the left segment bursts then the right segment bursts, one pitch further per line.
  function automatic void push_line(input int ln);
    req_t r;
    for (int b = 0; b < SEG0_W / BL; b++) begin
      r.src  = 1'b0;
      r.addr = 28'(SRC0_BASE + ln * STRIDE + b * BL);
      r.line = 12'(ln);
      exp_q.push_back(r);
    end
    for (int b = 0; b < SEG1_W / BL; b++) begin
      r.src  = 1'b1;
      r.addr = 28'(SRC1_BASE + SRC1_XOFF + ln * STRIDE + b * BL);
      r.line = 12'(ln);
      exp_q.push_back(r);
    end
  endfunction

  task automatic cyc();
    req_t e;
    @(negedge pixel_clk);
    if (just_acc) check_eq("req_gap", 32'(rd_if.rd_req), 32'd0);
    just_acc = 0;
    if (rd_if.rd_req) begin
      if (!waiting) begin
        waiting   = 1;
        cur_src   = rd_if.rd_src;
        cur_addr  = rd_if.rd_addr;
        wait_left = int'($urandom_range(hi, lo));
        check_eq("req_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          e = exp_q[0];
          check_eq("req_src", 32'(rd_if.rd_src), 32'(e.src));
          check_eq("req_addr", 32'(rd_if.rd_addr), 32'(e.addr));
          check_eq("req_line", 32'(line_idx), 32'(e.line));
        end
      end else begin
        check_eq("hold_src", 32'(rd_if.rd_src), 32'(cur_src));
        check_eq("hold_addr", 32'(rd_if.rd_addr), 32'(cur_addr));
      end
      if (wait_left == 0) begin
        rd_if.rd_ack = 1'b1;
        waiting  = 0;
        just_acc = 1;
        n_acc++;
        if (exp_q.size() != 0) void'(exp_q.pop_front());
      end else begin
        rd_if.rd_ack = 1'b0;
        wait_left--;
      end
    end else begin
      rd_if.rd_ack = 1'($urandom_range(1, 0));
    end
  endtask

  task automatic run_until_empty(input string tag, input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || rd_if.rd_req) && n < budget) begin
      cyc();
      n++;
    end
    check_eq({tag, "_done"}, 32'(exp_q.size()), 32'd0);
    cyc();
  endtask

  task automatic de_fall();
    video_de = 1'b1;
    repeat (3) cyc();
    video_de = 1'b0;
    cyc();
  endtask

  task automatic vs_rise();
    video_vs = 1'b0;
    repeat (2) cyc();
    video_vs = 1'b1;
    cyc();
  endtask

  initial begin
    int n;
    int n0;
    rd_if.rd_ack = 1'b0;

    sys_rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      video_vs = 1'($urandom);
      video_de = 1'($urandom);
      cyc();
      check_eq("rst_req", 32'(rd_if.rd_req), 32'd0);
      check_eq("rst_busy", 32'(busy), 32'd0);
    end
    video_vs = 1'b0;
    video_de = 1'b0;
    cyc();
    check_eq("rst_src", 32'(rd_if.rd_src), 32'd0);
    check_eq("rst_addr", 32'(rd_if.rd_addr), 32'd0);
    check_eq("rst_line", 32'(line_idx), 32'd0);
    check_eq("rst_overrun", 32'(overrun), 32'd0);
    check_eq("rst_len", 32'(rd_if.rd_len), 32'(BL));
    sys_rst = 1'b0;
    repeat (3) cyc();
    check_eq("idle_req", 32'(rd_if.rd_req), 32'd0);

    // frame start, ack one cycle after each request
    lo = 0; hi = 0;
    push_line(0);
    video_vs = 1'b1;
    cyc();
    cyc();
    check_eq("lat_early", 32'(rd_if.rd_req), 32'd0);
    cyc();
    check_eq("lat_req", 32'(rd_if.rd_req), 32'd1);
    run_until_empty("frame0", 100);
    cyc();
    check_eq("wait_line", 32'(line_idx), 32'd1);
    check_eq("wait_busy", 32'(busy), 32'd0);

    // remaining lines with random ack delay, then idle
    lo = 0; hi = 3;
    for (int ln = 1; ln < V_DISP; ln++) begin
      push_line(ln);
      de_fall();
      run_until_empty("line", 200);
    end
    check_eq("last_line", 32'(line_idx), 32'(V_DISP - 1));
    check_eq("last_busy", 32'(busy), 32'd0);
    n0 = n_acc;
    de_fall();
    repeat (20) cyc();
    check_eq("idle_no_req", 32'(n_acc), 32'(n0));

    // long ack delay on one line, random on the rest
    lo = 10; hi = 10;
    push_line(0);
    vs_rise();
    run_until_empty("slow0", 200);
    lo = 0; hi = 12;
    for (int ln = 1; ln < V_DISP; ln++) begin
      push_line(ln);
      de_fall();
      run_until_empty("rand", 300);
    end
    check_eq("rand_overrun", 32'(overrun), 32'd0);

    // line trigger during a fetch: overrun and back-to-back lines
    lo = 0; hi = 0;
    push_line(0);
    vs_rise();
    run_until_empty("ovr0", 100);
    lo = 20; hi = 20;
    push_line(1);
    push_line(2);
    de_fall();
    n = 0;
    while (!waiting && n < 50) begin cyc(); n++; end
    check_eq("l1_started", 32'(waiting), 32'd1);
    de_fall();
    check_eq("ovr_busy", 32'(busy), 32'd1);
    n = 0;
    while (exp_q.size() > 3 && n < 300) begin cyc(); n++; end
    check_eq("l1_done", 32'(exp_q.size()), 32'd3);
    n = 0;
    while (!waiting && n < 20) begin
      cyc();
      n++;
      check_eq("no_wait_busy", 32'(busy), 32'd1);
    end
    check_eq("l2_started", 32'(waiting), 32'd1);
    check_eq("overrun_set", 32'(overrun), 32'd1);

    // frame restart while a request is outstanding: it completes, then line 0 restarts
    lo = 0; hi = 2;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    push_line(0);
    vs_rise();
    check_eq("restart_hold", 32'(rd_if.rd_req), 32'd1);
    run_until_empty("restart", 300);
    cyc();
    check_eq("restart_overrun", 32'(overrun), 32'd0);
    check_eq("restart_line", 32'(line_idx), 32'd1);
    check_eq("restart_busy", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stitch_fetch_sched.md
# stitch_fetch_sched

Line-fetch scheduler for the stitched 2880-pixel output path. Follows the display timing generator's `video_vs` and `video_de`, then issues burst read requests to the DDR read port one line ahead of display. Each line is fetched as the left segment from frame buffer 0, followed by the right segment from frame buffer 1. It sits between the timing generator and the DDR read arbiter, which feeds the line FIFO ahead of `pixel_data`.

## Interface
- `SEG0_W`, 1920, pixels fetched per line from source 0; must be a multiple of `BURST_LEN`.
- `SEG1_W`, 960, pixels fetched per line from source 1; must be a multiple of `BURST_LEN`.
- `V_DISP`, 1080, active lines per frame.
- `BURST_LEN`, 64, pixels per read request; range 1–255.
- `ADDR_W`, 28, address width, in pixel-word units.
- `SRC0_BASE`, 0, frame-buffer 0 base address.
- `SRC1_BASE`, 'h400000, frame-buffer 1 base address.
- `STRIDE`, 1920, line pitch of both frame buffers.
- `SRC1_XOFF`, 960, first column read from source 1.
- `pixel_clk` in 1 — the single clock.
- `sys_rst` in 1 — synchronous, active-high reset.
- `video_vs` in 1 — timing generator vsync; low during the sync pulse.
- `video_de` in 1 — timing generator data enable.
- `rd_req` out 1 — read request, held until acknowledged.
- `rd_ack` in 1 — request accepted in this cycle.
- `rd_src` out 1 — selects source: 0 = left, 1 = right.
- `rd_addr` out `ADDR_W` — burst start address.
- `rd_len` out 8 — burst length; constant `BURST_LEN`.
- `line_idx` out 12 — line currently being fetched.
- `busy` out 1 — asserted in `S_SRC0` and `S_SRC1`.
- `overrun` out 1 — sticky flag; a line trigger arrived while the previous line was still being fetched.

## Operation
- The states are `S_IDLE`, `S_WAIT`, `S_SRC0` and `S_SRC1`.
- Edge detection:
  - `vs_d1/vs_d2` and `de_d1/de_d2` are two-stage registers on the timing inputs.
  - `frame_trig = vs_d1 & ~vs_d2`, i.e. the end of the sync pulse.
  - `line_trig = ~de_d1 & de_d2`, i.e. the end of the active line.
- `frame_trig` in any state:
  - Clears `line_idx`, `overrun` and the pending bit.
  - Loads `base0 = SRC0_BASE` and `base1 = SRC1_BASE + SRC1_XOFF`.
  - Enters `S_SRC0` with `burst = 0`.
  - If `rd_req` is high and not yet acked, the restart is latched and taken in the cycle after `rd_ack`. The outstanding request is never withdrawn.
- `S_SRC0`:
  - Drives `rd_req = 1`, `rd_src = 0`, `rd_addr = base0 + burst*BURST_LEN`.
  - On `rd_ack`, `burst` increments.
  - The ack on the last burst (`SEG0_W/BURST_LEN - 1`) clears `burst` and moves to `S_SRC1`.
- `S_SRC1`:
  - Same as `S_SRC0`, with `rd_src = 1` and `base1`.
  - The ack on the last burst ends the line.
- Line end:
  - If `line_idx == V_DISP-1`, go to `S_IDLE`.
  - Otherwise increment `line_idx`, add `STRIDE` to both `base0` and `base1`, then:
    - go to `S_SRC0` if the pending bit is set, clearing it;
    - otherwise go to `S_WAIT`.
- `S_WAIT`: `line_trig` moves to `S_SRC0` with `burst = 0`.
- `line_trig` while `busy`: sets `overrun` and the pending bit. The pending bit is one deep; further triggers only keep `overrun` set.
- `line_trig` in `S_IDLE` is ignored.
- A `frame_trig` and a `line_trig` in the same cycle: `frame_trig` wins.
- Arithmetic:
  - Address sums wrap modulo 2^`ADDR_W`.
  - `burst` is 8 bits wide.
  - `line_idx` saturates at `V_DISP-1`.

## Timing
- Reset values:
  - State is `S_IDLE`.
  - `rd_req = 0`, `rd_src = 0`, `rd_addr = 0`, `line_idx = 0`, `busy = 0`, `overrun = 0`.
  - `rd_len = BURST_LEN` constantly.
  - All delay registers are 0.
- All outputs are registered.
- Latency: `rd_req` rises 3 edges after the first edge that samples the new level of `video_vs` or `video_de`: d1, then the trigger registered into the FSM, then the output.
- Request handshake:
  - `rd_req`, `rd_src` and `rd_addr` are stable from assertion until the cycle `rd_ack` is sampled high.
  - The next request, if any, is presented on the following cycle. There is at most one request per 2 cycles.
- `rd_ack` while `rd_req = 0` is ignored.
- Reset mid-burst: `rd_req` drops on the next edge, with no completion required.

## Structure
- Shared package `stitch_pkg` holds:
  - the state enum;
  - the `BURST_LEN` and `ADDR_W` defaults;
  - the `rd_len` width constant.
- One sub-module, `sync_edge_det` (two flops plus rise/fall detection), instantiated for `vs` and for `de`.

## Test plan
Test parameters, unless a scenario states otherwise: `SEG0_W=128`, `SEG1_W=64`, `BURST_LEN=64`, `V_DISP=4`, `STRIDE=256`, `SRC1_BASE='h10000`, `SRC1_XOFF=64`.
- Reset held for 5 cycles with inputs toggling → all outputs hold their reset values and no `rd_req`.
- `vs` rises, `rd_ack` returned the cycle after each request → request sequence is (src 0, 0x0), (0, 0x40), (1, 0x10040); then `S_WAIT` with `line_idx = 1`.
- `de` falls 3 times → requests at 0x100, 0x140, 0x10140, then 0x200…, then 0x300, 0x340, 0x10340; then `S_IDLE`. A 4th `de` fall produces no request.
- `rd_ack` delayed 10 cycles → `rd_addr`/`rd_src` are stable throughout and no request is skipped.
- `de` falls during line 1 fetch, with ack delayed 20 cycles → `overrun = 1`; line 2 starts immediately after line 1 ends, with no `S_WAIT` entered.
- `vs` rises mid-line-2 while `rd_req` is pending → the current request completes on ack; the next request is (0, 0x0) with `line_idx = 0` and `overrun` cleared.
